// File: rtl/rom_read_scheduler.sv
// Purpose: small synchronous FIFO with a combinational head view, used as the scheduler's output buffer.
// Latency: a pushed entry is visible at the head in the cycle after the push.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module rom_read_scheduler_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [W-1:0]           push_dat_i,
  input  logic                   pop_i,
  output logic [W-1:0]           head_dat_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;

  // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
endmodule

// Purpose: round-robin sharing of one synchronous-read ROM port among NUM_REQ burst requesters.
// Latency: grant in cycle 0, ROM address in cycle 1, word 0 on out_valid in cycle 3, then 1 word/cycle.
// Backpressure: valid/ready output; reads stall when buffered plus in-flight words would exceed 2.
module rom_read_scheduler #(
  parameter  int NUM_REQ    = 4,
  parameter  int DEPTH      = 64,
  parameter  int WIDTH      = 32,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int LEN_WIDTH  = ADDR_WIDTH + 1,
  localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  output logic [ADDR_WIDTH-1:0]           rom_raddr,
  input  logic [WIDTH-1:0]                rom_rdata,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                out_data,
  output logic [ID_WIDTH-1:0]             out_id,
  output logic                            out_last,
  output logic                            busy
);
  localparam int BUF_W = WIDTH + ID_WIDTH + 1;

  typedef enum logic {IDLE, BURST} state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic [ID_WIDTH-1:0]   burst_id_q, burst_id_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [LEN_WIDTH-1:0]  words_left_q, words_left_d;
  logic                  in_flight_q, in_flight_d;
  logic                  in_flight_last_q, in_flight_last_d;

  logic [ADDR_WIDTH-1:0] req_addr_a [NUM_REQ];
  logic [LEN_WIDTH-1:0]  req_len_a  [NUM_REQ];

  logic                  grant_found;
  logic [ID_WIDTH-1:0]   grant_id;
  logic [ID_WIDTH-1:0]   cand;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic [LEN_WIDTH-1:0]  grant_len;

  logic [BUF_W-1:0]      buf_head;
  logic [1:0]            buf_cnt;
  logic                  pop;
  logic [2:0]            pending;
  logic                  issue;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_addr_a[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_len_a[g]  = req_len[g*LEN_WIDTH +: LEN_WIDTH];
  end

  // Round-robin pick: first valid requester searching upward from the one after the last grant.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_WIDTH'((int'(last_grant_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  assign accept     = (state_q == IDLE) && grant_found && !rst;
  assign req_ready  = accept ? (NUM_REQ'(1) << grant_id) : '0;
  assign grant_addr = req_addr_a[grant_id];
  assign grant_len  = req_len_a[grant_id];

  // A word enters the buffer the cycle after its address was presented to the ROM.
  rom_read_scheduler_fifo #(
    .W     (BUF_W),
    .DEPTH (2)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push_i     (in_flight_q),
    .push_dat_i ({rom_rdata, burst_id_q, in_flight_last_q}),
    .pop_i      (pop),
    .head_dat_o (buf_head),
    .count_o    (buf_cnt)
  );

  assign out_valid                    = (buf_cnt != 2'd0);
  assign {out_data, out_id, out_last} = buf_head;
  assign pop                          = out_valid && out_ready;

  // Words that will occupy the buffer next cycle if nothing new is issued now.
  assign pending = {1'b0, buf_cnt} + {2'b00, in_flight_q} - {2'b00, pop};
  assign issue   = (state_q == BURST) && (words_left_q != '0) && (pending < 3'd2);

  // Next-state logic: arbitration in IDLE, read issue and burst completion in BURST.
  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    burst_id_d       = burst_id_q;
    raddr_d          = raddr_q;
    words_left_d     = words_left_q;
    in_flight_d      = issue;
    in_flight_last_d = issue && (words_left_q == LEN_WIDTH'(1));
    case (state_q)
      IDLE: begin
        if (accept) begin
          last_grant_d = grant_id;
          // A zero-length request is consumed here and never enters BURST.
          if (grant_len != '0) begin
            state_d      = BURST;
            burst_id_d   = grant_id;
            raddr_d      = grant_addr;
            words_left_d = grant_len;
          end
        end
      end
      BURST: begin
        if (issue) begin
          raddr_d      = (raddr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : raddr_q + 1'b1;
          words_left_d = words_left_q - 1'b1;
        end
        if ((words_left_q == '0) && !in_flight_q && pop && out_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any outstanding words and restarts priority at requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      last_grant_q     <= ID_WIDTH'(NUM_REQ - 1);
      burst_id_q       <= '0;
      raddr_q          <= '0;
      words_left_q     <= '0;
      in_flight_q      <= 1'b0;
      in_flight_last_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      burst_id_q       <= burst_id_d;
      raddr_q          <= raddr_d;
      words_left_q     <= words_left_d;
      in_flight_q      <= in_flight_d;
      in_flight_last_q <= in_flight_last_d;
    end
  end

  assign rom_raddr = raddr_q;
  assign busy      = (state_q == BURST);
endmodule

// File: tb/tb_rom_read_scheduler.sv
// Bench for rom_read_scheduler: ROM model with mem[i] = 0x1000+i, 4 requesters, 64 words.
// A scoreboard predicts grants, busy and the ordered word stream from the arbitration rules.
// Directed tests pin latency, ordering, backpressure, wrap-around, zero length and reset.
module tb_rom_read_scheduler;
  localparam int AW = 6;
  localparam int LW = 7;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  id;
    logic        last;
  } word_t;

  logic          clk;
  logic          rst;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [4*AW-1:0] req_addr;
  logic [4*LW-1:0] req_len;
  logic [AW-1:0] rom_raddr;
  logic [31:0]   rom_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [1:0]    out_id;
  logic          out_last;
  logic          busy;

  logic [AW-1:0] a_arr [4];
  logic [LW-1:0] l_arr [4];
  logic [31:0]   rom [64];

  int    checks = 0;
  int    errors = 0;
  word_t exp_q[$];
  logic [31:0] got_q[$];
  logic [1:0]  m_last;
  logic [3:0]  acc_mask;
  bit    auto_drop;
  int    r1_pulses;

  rom_read_scheduler #(
    .NUM_REQ (4),
    .DEPTH   (64),
    .WIDTH   (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .rom_raddr (rom_raddr),
    .rom_rdata (rom_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h1000 + 32'(i);
  end

  always @(posedge clk) rom_rdata <= rom[rom_raddr];

  always_comb begin
    req_addr = '0;
    req_len  = '0;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*AW +: AW] = a_arr[i];
      req_len[i*LW +: LW]  = l_arr[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
    if (auto_drop) req_valid = req_valid & ~acc_mask;
  endtask

  task automatic set_req(input logic [1:0] id, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    a_arr[id]     = addr;
    l_arr[id]     = len;
    req_valid[id] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    next_cycle();
    while (exp_q.size() != 0 && n < 100) begin
      next_cycle();
      n++;
    end
    chk(name, 64'(exp_q.size()), 0);
  endtask

  // Collect n handshaken words; with use_pat, out_ready follows 1,0,0,1,0,1 repeating.
  task automatic collect(input int n, input bit use_pat);
    bit pat [6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    got_q.delete();
    for (int i = 0; i < 100; i++) begin
      out_ready = use_pat ? pat[i % 6] : 1'b1;
      @(negedge clk);
      chk("buf_occupancy_le2", 64'(dut.u_buf.count_o <= 2'd2), 1);
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (got_q.size() == n) break;
      next_cycle();
    end
    out_ready = 1'b1;
  endtask

  // Requester side: remember which request the DUT accepted this cycle.
  initial forever begin
    @(negedge clk);
    acc_mask = req_ready;
    if (req_ready[1]) r1_pulses++;
  end

  // Scoreboard: predicts the grant from the round-robin rule and checks every output cycle.
  initial begin : scoreboard
    logic [3:0] exp_ready;
    logic [1:0] g;
    logic [1:0] idx;
    bit         found;
    bit         prev_stall;
    word_t      prev_word;
    word_t      cur;
    word_t      w;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      cur = {out_data, out_id, out_last};
      if (rst) begin
        exp_q.delete();
        m_last     = 2'd3;
        prev_stall = 1'b0;
        chk("rst_req_ready", 64'(req_ready), 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_raddr", 64'(rom_raddr), 0);
        chk("rst_out_word", 64'(cur), 0);
      end else begin
        exp_ready = '0;
        g         = '0;
        if (exp_q.size() == 0 && req_valid != 4'd0) begin
          found = 1'b0;
          for (int k = 1; k <= 4; k++) begin
            idx = m_last + 2'(k);
            if (!found && req_valid[idx]) begin
              found = 1'b1;
              g     = idx;
            end
          end
          exp_ready[g] = 1'b1;
        end
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("busy", 64'(busy), 64'(exp_q.size() != 0));
        if (prev_stall) begin
          chk("stall_valid", 64'(out_valid), 1);
          chk("stall_word", 64'(cur), 64'(prev_word));
        end
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 64'(out_valid), 0);
          end else begin
            chk("word", 64'(cur), 64'(exp_q[0]));
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_word  = cur;
        if (exp_ready != 4'd0) begin
          m_last = g;
          for (int k = 0; k < int'(l_arr[g]); k++) begin
            w.data = 32'h1000 + 32'((int'(a_arr[g]) + k) % 64);
            w.id   = g;
            w.last = (k == int'(l_arr[g]) - 1);
            exp_q.push_back(w);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int gr_id [5];
    int gr_cyc [5];
    int exp_order [5];
    int n_gr;
    logic [31:0] wrap_exp [4];
    bit found_w2;
    exp_order = '{0, 1, 2, 3, 0};
    wrap_exp  = '{32'h103E, 32'h103F, 32'h1000, 32'h1001};
    rst       = 1'b1;
    req_valid = '0;
    out_ready = 1'b1;
    auto_drop = 1'b1;
    r1_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      a_arr[i] = '0;
      l_arr[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single burst: requester 2, addr 5, len 4, accepted in cycle 0.
    set_req(2, 5, 4);
    @(negedge clk);
    chk("t1_grant", 64'(req_ready), 64'h4);
    chk("t1_busy_c0", 64'(busy), 0);
    next_cycle();
    @(negedge clk);
    chk("t1_raddr_c1", 64'(rom_raddr), 5);
    chk("t1_busy_c1", 64'(busy), 1);
    chk("t1_valid_c1", 64'(out_valid), 0);
    next_cycle();
    @(negedge clk);
    chk("t1_valid_c2", 64'(out_valid), 0);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      @(negedge clk);
      chk("t1_valid", 64'(out_valid), 1);
      chk("t1_data", 64'(out_data), 64'(32'h1005 + 32'(k)));
      chk("t1_id", 64'(out_id), 2);
      chk("t1_last", 64'(out_last), 64'(k == 3));
    end
    next_cycle();
    @(negedge clk);
    chk("t1_busy_c7", 64'(busy), 0);
    chk("t1_valid_c7", 64'(out_valid), 0);

    // Round-robin: all four hold len-1 requests.
    do_reset();
    auto_drop = 1'b0;
    set_req(0, 10, 1);
    set_req(1, 20, 1);
    set_req(2, 30, 1);
    set_req(3, 40, 1);
    n_gr = 0;
    for (int cyc = 0; cyc < 60 && n_gr < 5; cyc++) begin
      @(negedge clk);
      if (req_ready != 4'd0) begin
        gr_id[n_gr]  = oh_idx(req_ready);
        gr_cyc[n_gr] = cyc;
        n_gr++;
      end
      if (n_gr < 5) next_cycle();
    end
    next_cycle();
    req_valid = '0;
    auto_drop = 1'b1;
    chk("rr_grant_count", 64'(n_gr), 5);
    for (int i = 0; i < n_gr; i++) begin
      chk("rr_order", 64'(gr_id[i]), 64'(exp_order[i]));
      if (i > 0) chk("rr_gap", 64'(gr_cyc[i] - gr_cyc[i-1]), 4);
    end
    wait_drain("rr_drain");

    // Backpressure: len 6 from requester 0 with out_ready toggling.
    set_req(0, 20, 6);
    collect(6, 1'b1);
    chk("bp_count", 64'(got_q.size()), 6);
    for (int k = 0; k < got_q.size(); k++) chk("bp_data", 64'(got_q[k]), 64'(32'h1014 + 32'(k)));
    wait_drain("bp_drain");

    // Wrap-around: addr 62, len 4.
    set_req(3, 62, 4);
    collect(4, 1'b0);
    chk("wrap_count", 64'(got_q.size()), 4);
    for (int k = 0; k < got_q.size(); k++) chk("wrap_data", 64'(got_q[k]), 64'(wrap_exp[k]));
    wait_drain("wrap_drain");

    // Zero length on requester 1 with requester 2 pending.
    do_reset();
    r1_pulses = 0;
    set_req(1, 0, 0);
    set_req(2, 33, 2);
    @(negedge clk);
    chk("zl_grant1", 64'(req_ready), 64'h2);
    chk("zl_busy_c0", 64'(busy), 0);
    next_cycle();
    @(negedge clk);
    chk("zl_grant2", 64'(req_ready), 64'h4);
    chk("zl_busy_c1", 64'(busy), 0);
    wait_drain("zl_drain");
    chk("zl_ready1_pulses", 64'(r1_pulses), 1);

    // Reset during word 2 of a len-8 burst.
    set_req(1, 40, 8);
    found_w2 = 1'b0;
    for (int i = 0; i < 30 && !found_w2; i++) begin
      @(negedge clk);
      if (out_valid && out_data == 32'h102A) found_w2 = 1'b1;
      else next_cycle();
    end
    chk("rmb_word2_seen", 64'(found_w2), 1);
    #1 rst = 1'b1;
    #1;
    chk("rmb_out_valid", 64'(out_valid), 0);
    chk("rmb_busy", 64'(busy), 0);
    chk("rmb_raddr", 64'(rom_raddr), 0);
    chk("rmb_out_data", 64'(out_data), 0);
    chk("rmb_out_id", 64'(out_id), 0);
    chk("rmb_out_last", 64'(out_last), 0);
    chk("rmb_req_ready", 64'(req_ready), 0);
    req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    set_req(0, 7, 2);
    set_req(3, 50, 1);
    @(negedge clk);
    chk("rmb_grant0", 64'(req_ready), 64'h1);
    next_cycle();
    @(negedge clk);
    chk("rmb_new_raddr", 64'(rom_raddr), 7);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rmb_new_valid", 64'(out_valid), 1);
    chk("rmb_new_data", 64'(out_data), 64'h1007);
    wait_drain("rmb_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
